// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, reset vector, branch-resolve FSM states.
package core_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {BR_IDLE, BR_CMP, BR_UPD} br_state_t;

  // Strobe vector order: {jalr, jal, bgeu, bltu, bge, blt, bne, beq}
  localparam int unsigned NUM_STROBES = 8;

  function automatic logic multi_hot(input logic [NUM_STROBES-1:0] s);
    return (s & (s - 1'b1)) != '0;
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator; jumps are unconditionally taken.
module branch_cmp
  import core_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            beq,
  input  logic            bne,
  input  logic            blt,
  input  logic            bge,
  input  logic            bltu,
  input  logic            bgeu,
  input  logic            jal,
  input  logic            jalr,
  output logic            cmp_taken
);

  logic eq;
  logic lt;
  logic ltu;

  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);

  assign cmp_taken = (beq & eq) | (bne & ~eq) | (blt & lt) | (bge & ~lt) |
                     (bltu & ltu) | (bgeu & ~ltu) | jal | jalr;

endmodule

// File: rtl/branch_resolve.sv
// Multicycle branch/jump resolver owning the architectural PC (IDLE -> CMP -> UPD).
module branch_resolve
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            pc_inc,
  input  logic            beq,
  input  logic            bne,
  input  logic            blt,
  input  logic            bge,
  input  logic            bltu,
  input  logic            bgeu,
  input  logic            jal,
  input  logic            jalr,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] link_addr,
  output logic            taken,
  output logic            done,
  output logic            busy,
  output logic            misaligned,
  output logic            illegal
);

  br_state_t state_q, state_d;

  logic [NUM_STROBES-1:0] strb_q;
  logic [XLEN-1:0] a_q, b_q, imm_q, pc_lat_q;
  logic [XLEN-1:0] pc_q, link_q, target_q;
  logic            cmp_taken_q;
  logic            done_q, taken_q, misaligned_q, illegal_q;

  logic            cmp_taken;
  logic [XLEN-1:0] sum, target_d, seq_pc;
  logic            illegal_op, misalign_op, redirect;

  branch_cmp u_cmp (
    .a        (a_q),
    .b        (b_q),
    .beq      (strb_q[0]),
    .bne      (strb_q[1]),
    .blt      (strb_q[2]),
    .bge      (strb_q[3]),
    .bltu     (strb_q[4]),
    .bgeu     (strb_q[5]),
    .jal      (strb_q[6]),
    .jalr     (strb_q[7]),
    .cmp_taken(cmp_taken)
  );

  // jalr adds to rs1 and clears bit 0; everything else is pc-relative.
  assign sum      = (strb_q[7] ? a_q : pc_lat_q) + imm_q;
  assign target_d = strb_q[7] ? {sum[XLEN-1:1], 1'b0} : sum;
  assign seq_pc   = pc_lat_q + XLEN'(PC_STEP);

  // An illegal op never redirects, so it also never reports misalignment.
  assign illegal_op  = multi_hot(strb_q);
  assign misalign_op = cmp_taken_q & ~illegal_op & (target_q[1:0] != 2'b00);
  assign redirect    = cmp_taken_q & ~illegal_op & ~misalign_op;

  always_ff @(posedge clk) begin
    if (rst) state_q <= BR_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BR_IDLE: if (start) state_d = BR_CMP;
      BR_CMP:  state_d = BR_UPD;
      BR_UPD:  state_d = BR_IDLE;
      default: state_d = BR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      link_q       <= '0;
      strb_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      imm_q        <= '0;
      pc_lat_q     <= '0;
      target_q     <= '0;
      cmp_taken_q  <= 1'b0;
      done_q       <= 1'b0;
      taken_q      <= 1'b0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      taken_q      <= 1'b0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
      unique case (state_q)
        BR_IDLE: begin
          if (start) begin
            strb_q   <= {jalr, jal, bgeu, bltu, bge, blt, bne, beq};
            a_q      <= rs1_val;
            b_q      <= rs2_val;
            imm_q    <= imm;
            pc_lat_q <= pc_q;
          end else if (pc_inc) begin
            pc_q <= pc_q + XLEN'(PC_STEP);
          end
        end
        BR_CMP: begin
          cmp_taken_q <= cmp_taken;
          target_q    <= target_d;
        end
        BR_UPD: begin
          pc_q         <= redirect ? target_q : seq_pc;
          link_q       <= seq_pc;
          done_q       <= 1'b1;
          taken_q      <= redirect;
          misaligned_q <= misalign_op;
          illegal_q    <= illegal_op;
        end
        default: ;
      endcase
    end
  end

  assign pc         = pc_q;
  assign pc_plus4   = pc_q + XLEN'(PC_STEP);
  assign link_addr  = link_q;
  assign taken      = taken_q;
  assign done       = done_q;
  assign busy       = (state_q != BR_IDLE);
  assign misaligned = misaligned_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed cases plus randomized ops vs a
// transaction-level reference model.
module tb_branch_resolve;
  import core_pkg::*;

  logic            clk = 1'b0;
  logic            rst, start, pc_inc;
  logic            beq, bne, blt, bge, bltu, bgeu, jal, jalr;
  logic [XLEN-1:0] rs1_val, rs2_val, imm;
  logic [XLEN-1:0] pc, pc_plus4, link_addr;
  logic            taken, done, busy, misaligned, illegal;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] ref_pc;

  localparam logic [7:0] S_BEQ  = 8'h01;
  localparam logic [7:0] S_BNE  = 8'h02;
  localparam logic [7:0] S_BLT  = 8'h04;
  localparam logic [7:0] S_BLTU = 8'h10;
  localparam logic [7:0] S_BGEU = 8'h20;
  localparam logic [7:0] S_JAL  = 8'h40;
  localparam logic [7:0] S_JALR = 8'h80;

  branch_resolve dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pc_inc    (pc_inc),
    .beq       (beq),
    .bne       (bne),
    .blt       (blt),
    .bge       (bge),
    .bltu      (bltu),
    .bgeu      (bgeu),
    .jal       (jal),
    .jalr      (jalr),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .imm       (imm),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .link_addr (link_addr),
    .taken     (taken),
    .done      (done),
    .busy      (busy),
    .misaligned(misaligned),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_strb(input logic [7:0] s);
    {jalr, jal, bgeu, bltu, bge, blt, bne, beq} = s;
  endtask

  // Architectural branch condition straight from the ISA definition.
  function automatic bit ref_cond(input logic [7:0] s, input logic [31:0] a,
                                  input logic [31:0] b);
    if (s[0]) return a == b;
    if (s[1]) return a != b;
    if (s[2]) return $signed(a) < $signed(b);
    if (s[3]) return $signed(a) >= $signed(b);
    if (s[4]) return a < b;
    if (s[5]) return a >= b;
    if (s[6] || s[7]) return 1'b1;
    return 1'b0;
  endfunction

  // Issues one op and checks the full 3-cycle transaction; returns in the done cycle.
  task automatic run_op(input logic [7:0] s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input bit with_inc, input bit inc_busy);
    logic [31:0] tgt, seq, exp_pc;
    bit          ill, raw, mis, tk;
    seq    = ref_pc + 32'd4;
    ill    = $countones(s) > 1;
    raw    = !ill && ref_cond(s, a, b);
    tgt    = s[7] ? ((a + im) & 32'hFFFF_FFFE) : (ref_pc + im);
    mis    = raw && (tgt[1:0] != 2'b00);
    tk     = raw && !mis;
    exp_pc = tk ? tgt : seq;

    start = 1'b1; pc_inc = with_inc; set_strb(s);
    rs1_val = a; rs2_val = b; imm = im;
    tick;
    start = 1'b0; pc_inc = inc_busy; set_strb(8'($urandom));
    rs1_val = $urandom; rs2_val = $urandom; imm = $urandom;
    check("busy_cmp", busy, 1); check("done_cmp", done, 0);
    tick;
    check("busy_upd", busy, 1); check("done_upd", done, 0);
    tick;
    pc_inc = 1'b0;
    check("done", done, 1);
    check("busy_done", busy, 0);
    check("pc", pc, exp_pc);
    check("taken", taken, tk);
    check("link", link_addr, seq);
    check("misaligned", misaligned, mis);
    check("illegal", illegal, ill);
    ref_pc = exp_pc;
  endtask

  task automatic idle_check;
    tick;
    check("done_pulse", done, 0);
    check("taken_pulse", taken, 0);
    check("mis_pulse", misaligned, 0);
    check("ill_pulse", illegal, 0);
    check("pc_hold", pc, ref_pc);
  endtask

  task automatic step_inc;
    pc_inc = 1'b1;
    tick;
    pc_inc = 1'b0;
    ref_pc = ref_pc + 32'd4;
    check("pc_inc", pc, ref_pc);
    check("pc_inc_done", done, 0);
    check("pc_inc_busy", busy, 0);
    check("pc_plus4", pc_plus4, ref_pc + 32'd4);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pc_inc = 1'b0; set_strb(8'h00);
    rs1_val = '0; rs2_val = '0; imm = '0;
    tick; tick;
    rst = 1'b0;
    ref_pc = RESET_PC;
    check("rst_pc", pc, RESET_PC);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_taken", taken, 0);
    check("rst_link", link_addr, 0);
    check("rst_mis", misaligned, 0);
    check("rst_ill", illegal, 0);

    repeat (3) step_inc;
    check("pc_0xC", pc, 32'h0000_000C);

    run_op(S_JAL, 0, 0, 32'h100 - ref_pc, 0, 0); idle_check;
    check("pc_0x100", pc, 32'h0000_0100);
    run_op(S_BEQ, 5, 5, 32'h20, 0, 0);
    check("beq_taken_pc", pc, 32'h0000_0120); idle_check;
    run_op(S_BEQ, 5, 6, 32'h20, 0, 0); idle_check;
    run_op(S_BLT,  32'hFFFF_FFFF, 1, 32'h40, 0, 0); idle_check;
    run_op(S_BLTU, 32'hFFFF_FFFF, 1, 32'h40, 0, 0); idle_check;
    run_op(S_BGEU, 32'hFFFF_FFFF, 1, 32'h40, 0, 0); idle_check;

    run_op(S_JAL, 0, 0, 32'h200 - ref_pc, 0, 0); idle_check;
    run_op(S_JALR, 32'h1001, 0, 32'h4, 0, 0);
    check("jalr_pc", pc, 32'h0000_1004);
    check("jalr_link", link_addr, 32'h0000_0204); idle_check;
    run_op(S_JAL, 0, 0, 32'h200 - ref_pc, 0, 0); idle_check;
    run_op(S_JAL, 0, 0, 32'h6, 0, 0);
    check("jal_mis_pc", pc, 32'h0000_0204); idle_check;

    run_op(S_BNE, 1, 2, 32'h10, 1, 1); idle_check;
    run_op(S_BEQ | S_BNE, 3, 3, 32'h10, 0, 0); idle_check;
    run_op(S_BEQ, 7, 7, 32'h8, 0, 0);
    run_op(S_BNE, 7, 7, 32'h8, 0, 0); idle_check;

    for (int k = 0; k < 200; k++) begin
      logic [7:0]  s;
      logic [31:0] a, b, im;
      int unsigned r, i, j;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        s = 8'h00;
      end else if (r < 3) begin
        i = $urandom_range(0, 7);
        j = (i + $urandom_range(1, 7)) % 8;
        s = (8'd1 << i) | (8'd1 << j);
      end else begin
        s = 8'd1 << $urandom_range(0, 7);
      end
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      im = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      run_op(s, a, b, im, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_check;
      if ($urandom_range(0, 4) == 0) step_inc;
    end

    tick;
    start = 1'b1; set_strb(S_BEQ); rs1_val = 1; rs2_val = 1; imm = 32'h40;
    tick;
    start = 1'b0;
    check("cmp_busy_pre_rst", busy, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    ref_pc = RESET_PC;
    check("rst_cmp_pc", pc, RESET_PC);
    check("rst_cmp_busy", busy, 0);
    check("rst_cmp_done", done, 0);
    repeat (3) begin
      tick;
      check("no_done_after_rst", done, 0);
      check("pc_after_rst", pc, RESET_PC);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
